// File: rtl/display_scan_driver.sv
// display_scan_driver
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment
// display. It steps a one-hot-low digit select through the four digits and
// reads the selected digit back from the external selector. It decodes that
// digit to registered active-low segments and drives the anode pins. Every
// slot opens with a blanking interval so the previous digit never ghosts
// onto the next one.

module display_scan_driver #(
    parameter int SCAN_DIV     = 20000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] digit_in,
    output logic [3:0] sel,
    output logic [3:0] anode,
    output logic [6:0] seg,
    output logic       frame_start
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] LAST_BLNK = CW'(BLANK_CYCLES - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } phase_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    phase_t        phase_q, phase_d;
    logic [3:0]    sel_q, sel_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_q, frame_d;
    logic          lit;

    // Active-low segment pattern for one BCD/hex digit; 10..15 show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Next-state logic. The pins are decided from the phase the next cycle
    // will be in, so anode/seg change on the same edge as cnt and sel.
    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        phase_d = phase_q;
        frame_d = 1'b0;
        if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            phase_d = BLANK;
            frame_d = (idx_q == 2'd3);
        end else if (cnt_q == LAST_BLNK) begin
            phase_d = SHOW;
        end

        case (idx_d)
            2'd0:    sel_d = 4'b0111;
            2'd1:    sel_d = 4'b1011;
            2'd2:    sel_d = 4'b1101;
            default: sel_d = 4'b1110;
        endcase

        // digit_in belongs to sel_q; whenever lit is set the slot does not
        // change on this edge, so sel_d equals sel_q and the digit matches.
        lit     = (phase_d == SHOW) && enable;
        anode_d = lit ? sel_d : 4'b1111;
        seg_d   = lit ? decode(digit_in) : 7'b1111111;
    end

    // Scan state and registered pin outputs, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            phase_q <= BLANK;
            sel_q   <= 4'b0111;
            anode_q <= 4'b1111;
            seg_q   <= 7'b1111111;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            sel_q   <= sel_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign sel         = sel_q;
    assign anode       = anode_q;
    assign seg         = seg_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver
// Scoreboard bench for display_scan_driver with SCAN_DIV=8 and BLANK_CYCLES=2.
// The stimulus side pushes the expected pin state for each cycle that follows
// a reset release. A monitor pops each entry on the falling edge of its cycle
// and compares. The monitor also watches for ghosting on every cycle.

module tb_display_scan_driver;

    typedef struct {
        int         scn;
        int         cyc;
        logic [3:0] sel;
        logic [3:0] anode;
        logic [6:0] seg;
        logic       frame;
    } exp_t;

    localparam logic [3:0] SEL_TAB [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [3:0] digitIn;
    logic [3:0] sel;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       frameStart;

    logic [3:0] digits [4];
    exp_t       expQ [$];
    exp_t       monEntry;
    int         cycleCount = 0;
    int         checks = 0;
    int         errors = 0;
    bit         ghostOn = 1'b0;
    logic [3:0] prevSel = 4'b0111;

    display_scan_driver #(
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digit_in   (digitIn),
        .sel        (sel),
        .anode      (anode),
        .seg        (seg),
        .frame_start(frameStart)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Cycle index since reset release; it reads 0 for the reset cycles themselves.
    always @(posedge clk) begin
        if (!reset) cycleCount = 0;
        else        cycleCount = cycleCount + 1;
    end

    // Model of the external BCD digit selector: returns the digit chosen by sel.
    always_comb begin
        digitIn = 4'h0;
        case (sel)
            4'b0111: digitIn = digits[0];
            4'b1011: digitIn = digits[1];
            4'b1101: digitIn = digits[2];
            4'b1110: digitIn = digits[3];
            default: digitIn = 4'h0;
        endcase
    end

    // Expected pin state at cycle c of scenario scn. Scenario 2 feeds digits
    // 4f..4f+3 in frame f. Scenario 3 has enable low for the edges that
    // produce cycles 21..36.
    function automatic exp_t expectAt(input int scn, input int c);
        exp_t r;
        int   slot;
        int   cnt;
        int   d;
        bit   en;
        bit   lit;
        slot = (c / 8) % 4;
        cnt  = c % 8;
        d    = (scn == 2) ? ((c / 32) * 4 + slot) : (slot + 1);
        en   = !(scn == 3 && c >= 21 && c <= 36);
        lit  = (cnt >= 2) && en;
        r.scn   = scn;
        r.cyc   = c;
        r.sel   = SEL_TAB[slot];
        r.anode = lit ? SEL_TAB[slot] : 4'b1111;
        r.seg   = lit ? SEG_TAB[4'(d)] : 7'b1111111;
        r.frame = (c > 0) && (cnt == 0) && (slot == 0);
        return r;
    endfunction

    // Push the expected pin state for cycles first..last of a scenario.
    task automatic applyStimulus(input int scn, input int first, input int last);
        for (int c = first; c <= last; c++) expQ.push_back(expectAt(scn, c));
    endtask

    // Compare one scoreboard entry with the live DUT pins.
    task automatic checkOutput(input exp_t e);
        checks++;
        if (sel !== e.sel || anode !== e.anode || seg !== e.seg || frameStart !== e.frame) begin
            errors++;
            $display("[TB] FAIL pins scn=%0d cyc=%0d got sel=%b anode=%b seg=%b fs=%b want sel=%b anode=%b seg=%b fs=%b",
                     e.scn, e.cyc, sel, anode, seg, frameStart, e.sel, e.anode, e.seg, e.frame);
        end
    endtask

    // Monitor: pop and check the entry for this cycle. Then check that lit
    // anodes never overlap a sel change and never disagree with sel.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            if (expQ[0].cyc == cycleCount) begin
                monEntry = expQ.pop_front();
                checkOutput(monEntry);
            end else if (expQ[0].cyc < cycleCount) begin
                monEntry = expQ.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missed scn=%0d cyc=%0d got cycle=%0d want cycle=%0d",
                         monEntry.scn, monEntry.cyc, cycleCount, monEntry.cyc);
            end
        end
        if (ghostOn) begin
            if (sel !== prevSel) begin
                checks++;
                if (anode !== 4'b1111 || seg !== 7'b1111111) begin
                    errors++;
                    $display("[TB] FAIL ghostSelChange cyc=%0d got anode=%b seg=%b want anode=1111 seg=1111111",
                             cycleCount, anode, seg);
                end
            end
            if (anode !== 4'b1111) begin
                checks++;
                if (anode !== sel) begin
                    errors++;
                    $display("[TB] FAIL ghostAnodeSel cyc=%0d got anode=%b want anode=%b",
                             cycleCount, anode, sel);
                end
            end
            prevSel = sel;
        end
    end

    // Reset from a falling edge: check the reset state, hold two edges, release.
    task automatic resetDut(input int scn);
        reset = 1'b0;
        @(posedge clk);
        #1;
        expQ.push_back(expectAt(scn, 0));
        ghostOn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Advance to the falling edge of cycle n; an overrun counts as a failure.
    task automatic waitCycle(input int n);
        int guard;
        guard = 0;
        @(negedge clk);
        while (cycleCount != n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (cycleCount != n) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitCycle got cycle=%0d want cycle=%0d", cycleCount, n);
        end
    endtask

    // Wait until the monitor has consumed every expected entry.
    task automatic waitDrain();
        int guard;
        guard = 0;
        while (expQ.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain got pending=%0d want pending=0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        digits[0] = 4'd1;
        digits[1] = 4'd2;
        digits[2] = 4'd3;
        digits[3] = 4'd4;
        @(negedge clk);

        // Scenario 1: reset values, counter wrap, full scan of 1,2,3,4, frame pulses.
        $display("[TB] scenario 1: reset, wrap and full scan");
        resetDut(1);
        applyStimulus(1, 1, 130);
        waitDrain();

        // Scenario 2: decode sweep of 0..15, four digits per frame.
        $display("[TB] scenario 2: decode sweep");
        digits[0] = 4'd0;
        digits[1] = 4'd1;
        digits[2] = 4'd2;
        digits[3] = 4'd3;
        resetDut(2);
        applyStimulus(2, 1, 127);
        for (int f = 1; f < 4; f++) begin
            waitCycle(32 * f);
            for (int s = 0; s < 4; s++) digits[s] = 4'(4 * f + s);
        end
        waitDrain();

        // Scenario 3: enable drop at cycle 20, frame pulse at 32, restore at 36.
        $display("[TB] scenario 3: enable gating");
        digits[0] = 4'd1;
        digits[1] = 4'd2;
        digits[2] = 4'd3;
        digits[3] = 4'd4;
        resetDut(3);
        applyStimulus(3, 1, 40);
        waitCycle(20);
        enable = 1'b0;
        waitCycle(36);
        enable = 1'b1;
        waitDrain();

        // Scenario 4: reset mid-SHOW at cycle 13, then slot 0 timing repeats.
        $display("[TB] scenario 4: reset mid-show");
        resetDut(4);
        applyStimulus(4, 1, 12);
        waitCycle(13);
        resetDut(4);
        applyStimulus(4, 1, 20);
        waitDrain();

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Time-multiplexed scan controller for the 4-digit common-anode 7-segment display. It drives the digit-select code into the existing BCD digit selector, takes the selected 4-bit digit back, and decodes it to registered active-low segments. It also drives the physical anodes, inserting a blanking interval at every digit change so the previous digit does not ghost. It sits between the digit registers (UART receive path) and the board pins.

## Interface
- SCAN_DIV, 20000: clock cycles per digit slot; legal values are ≥ BLANK_CYCLES+2.
- BLANK_CYCLES, 100: cycles at the start of each slot with all anodes off; legal values are ≥ 2.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  display enable. When low, pins are blanked and scanning continues.
- digit_in  in  4  BCD/hex digit returned by the selector for the current `sel`.
- sel  out  4  one-hot-low digit select to the selector: 0111 = digit1 (right), 1011 = digit2, 1101 = digit3, 1110 = digit4 (left).
- anode  out  4  active-low anode pins, same encoding as `sel`.
- seg  out  7  active-low segments, seg[0]=a … seg[6]=g.
- frame_start  out  1  one-cycle pulse at the start of each 4-digit frame.

## Operation
- **State:** slot counter `cnt` (0..SCAN_DIV-1), slot index `idx` (0..3), and phase BLANK/SHOW.
- **Scan order:** idx 0→1→2→3→0, with `sel` = 0111, 1011, 1101, 1110 respectively.
- **Counter wrap:**
  - `cnt` increments every cycle.
  - At `cnt` = SCAN_DIV-1, `cnt`→0 and `idx` advances modulo 4.
  - `sel` updates on that same edge, so it changes only at slot start.
- **Phase:** BLANK while `cnt` < BLANK_CYCLES, SHOW otherwise.
- **anode:**
  - 1111 in BLANK or when `enable`=0.
  - Equal to `sel` in SHOW with `enable`=1.
- **seg:**
  - Registered every cycle.
  - Forced to 1111111 when the next-cycle phase is BLANK or `enable`=0.
  - Otherwise seg = decode(digit_in).
- **Decode (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 = 0111111 (dash, segment g only).
- **frame_start:** high for exactly the one cycle in which `idx` has just become 0 from 3 (`cnt`=0, `sel`=0111).
- **enable:** gates only `anode`/`seg`. Counters and `frame_start` run regardless, so frame timing is unaffected by enable toggles.
- **Reset (any time, including mid-slot):**
  - On the next edge: `cnt`=0, `idx`=0, `sel`=0111, `anode`=1111, `seg`=1111111, `frame_start`=0.
  - Scanning restarts at slot 0, BLANK phase.

## Timing
- A slot is SCAN_DIV cycles: BLANK_CYCLES blank cycles, then SCAN_DIV-BLANK_CYCLES lit cycles. A frame is 4·SCAN_DIV cycles.
- **First lit cycle:** `anode` goes active on the first cycle with `cnt`=BLANK_CYCLES.
- **Segment setup:** `seg` already holds that slot's decoded digit on that cycle. `sel` was stable since `cnt`=0, which gives ≥2 cycles for the selector and register.
- **Slot end:** `anode` returns to 1111 on the cycle `cnt` becomes 0, the same edge on which `sel` changes.
- **seg blanking:** `seg` goes 1111111 on that same edge; lit segments never overlap a `sel` change.
- **Enable latency:**
  - `enable` deassert: `anode`=1111 and `seg`=1111111 one cycle later (registered).
  - `enable` reassert mid-SHOW: the current digit lights one cycle later.
- **After reset release:** the first `frame_start` pulse occurs 4·SCAN_DIV cycles later. There is no pulse during or immediately after reset.
- `digit_in` changing mid-SHOW appears on `seg` one cycle later. Coherent frame updates are the writer's job, using `frame_start`.

## Test plan
- **Reset values and counter wrap** (SCAN_DIV=8, BLANK_CYCLES=2):
  - During reset: `sel`=0111, `anode`=1111, `seg`=1111111.
  - After release: `anode`=0111 at cycles 2–7, then 1111 at cycles 8–9, then 1011 at cycles 10–15.
- **Full scan** with the selector model fed digits 1,2,3,4:
  - Per slot, `seg` = 1111001, 0100100, 0110000, 0011001 with matching anodes.
  - `frame_start` pulses at cycles 32, 64, 96, …
- **Decode sweep:** digit_in 0–15, one per slot → the listed codes; 10–15 all give 0111111.
- **Enable:**
  - `enable`=0 at cycle 20 → `anode`=1111 and `seg`=1111111 from cycle 21.
  - `frame_start` still fires at cycle 32.
  - `enable`=1 at cycle 36 → `anode`=0111 at cycle 37.
- **Reset mid-SHOW** at cycle 13 → next edge gives `sel`=0111 and `anode`=1111. After release, the slot 0 timing from the first scenario repeats exactly.
- **Ghosting check:** on every cycle where `sel` changes, assert `anode`=1111 and `seg`=1111111; assert `anode` is never low while `sel` ≠ `anode`.
